// File: rtl/mbconv_pkg.sv
// rtl/mbconv_pkg.sv - shared state type, lane constants and lane-slice helper
package mbconv_pkg;

  localparam int NUM_PE = 16;
  localparam int OFM_DW = 8;
  localparam int LANE_W = $clog2(NUM_PE);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_IFM,
    COMPUTE,
    DRAIN,
    DONE
  } seq_state_e;

  function automatic logic [OFM_DW-1:0] lane_slice(
    input logic [NUM_PE*OFM_DW-1:0] vec,
    input logic [LANE_W-1:0]        lane
  );
    return vec[int'(lane)*OFM_DW +: OFM_DW];
  endfunction

endpackage

// File: rtl/ofm_serializer.sv
// rtl/ofm_serializer.sv - one-vector OFM capture buffer drained lane by lane over valid/ready
module ofm_serializer
  import mbconv_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     capture_en_i,
  input  logic                     ovf_clr_i,
  input  logic [NUM_PE*OFM_DW-1:0] vec_i,
  input  logic                     vec_valid_i,
  output logic [OFM_DW-1:0]        ofm_data_o,
  output logic [LANE_W-1:0]        ofm_lane_o,
  output logic                     ofm_valid_o,
  input  logic                     ofm_ready_i,
  output logic                     full_next_o,
  output logic                     overflow_o
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_PE - 1);

  logic [NUM_PE*OFM_DW-1:0] vec_q, vec_d;
  logic                     full_q, full_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic                     ovf_q, ovf_d;
  logic                     beat, last_beat, capture, drop;

  assign beat      = full_q & ofm_ready_i;
  assign last_beat = beat & (lane_q == LAST_LANE);
  // The slot freed by the lane-15 beat can take a new vector in the same cycle.
  assign capture   = capture_en_i & vec_valid_i & (~full_q | last_beat);
  assign drop      = capture_en_i & vec_valid_i & full_q & ~last_beat;

  always_comb begin
    vec_d  = vec_q;
    full_d = full_q;
    lane_d = lane_q;
    ovf_d  = ovf_q;
    if (beat) begin
      lane_d = lane_q + LANE_W'(1);
    end
    if (last_beat) begin
      full_d = 1'b0;
      lane_d = '0;
    end
    if (capture) begin
      vec_d  = vec_i;
      full_d = 1'b1;
      lane_d = '0;
    end
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (clear_i) begin
      vec_d  = '0;
      full_d = 1'b0;
      lane_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vec_q  <= '0;
      full_q <= 1'b0;
      lane_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      full_q <= full_d;
      lane_q <= lane_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ofm_valid_o = full_q;
  assign ofm_lane_o  = lane_q;
  assign ofm_data_o  = lane_slice(vec_q, lane_q);
  assign full_next_o = full_d;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/mbconv_layer_sequencer.sv
// rtl/mbconv_layer_sequencer.sv - per-layer LOAD_W/LOAD_IFM/COMPUTE/DRAIN sequencer for MB_CONV
module mbconv_layer_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_PE = 16,
  parameter int OFM_DW = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        w_words,
  input  logic [ADDR_W-1:0]        ifm_words,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_PE-1:0]        w_wr_en,
  output logic [ADDR_W-1:0]        w_wr_addr,
  output logic                     ifm_wr_en,
  output logic [ADDR_W-1:0]        ifm_wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     cal_start,
  input  logic                     done_compute,
  input  logic [NUM_PE*OFM_DW-1:0] ofm_vec,
  input  logic                     ofm_vec_valid,
  output logic [OFM_DW-1:0]        ofm_data,
  output logic [3:0]               ofm_lane,
  output logic                     ofm_valid,
  input  logic                     ofm_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);
  import mbconv_pkg::*;

  localparam int SHIFT_W = $clog2(NUM_PE);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] w_total_q, w_total_d;
  logic [ADDR_W-1:0] ifm_total_q, ifm_total_d;
  logic [ADDR_W-1:0] cnt_inc, w_product;

  logic [NUM_PE-1:0] w_wr_en_q;
  logic [ADDR_W-1:0] w_wr_addr_q, ifm_wr_addr_q;
  logic              ifm_wr_en_q;
  logic [DATA_W-1:0] wr_data_q;

  logic load_w, load_ifm, accept, buf_full_d, ovf_clr;

  assign load_w    = (state_q == LOAD_W);
  assign load_ifm  = (state_q == LOAD_IFM);
  assign in_ready  = load_w | load_ifm;
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = cnt_q + ADDR_W'(1);
  // A product that truncates to zero is treated like w_words == 0.
  assign w_product = w_words << SHIFT_W;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_total_d   = w_total_q;
    ifm_total_d = ifm_total_q;
    ovf_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (run) begin
          w_total_d   = w_product;
          ifm_total_d = ifm_words;
          ovf_clr     = ~abort;
          if (w_product != '0) begin
            state_d = LOAD_W;
          end else if (ifm_words != '0) begin
            state_d = LOAD_IFM;
          end else begin
            state_d = COMPUTE;
          end
        end
      end
      LOAD_W: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == w_total_q) begin
            cnt_d   = '0;
            state_d = (ifm_total_q != '0) ? LOAD_IFM : COMPUTE;
          end
        end
      end
      LOAD_IFM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == ifm_total_q) begin
            cnt_d   = '0;
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        // buf_full_d already includes a vector arriving together with done_compute.
        if (done_compute) begin
          state_d = buf_full_d ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (!buf_full_d) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      w_total_q   <= '0;
      ifm_total_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_total_q   <= w_total_d;
      ifm_total_q <= ifm_total_d;
    end
  end

  // Weight lane = low bits of the accept count, weight address = the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_wr_en_q     <= '0;
      w_wr_addr_q   <= '0;
      ifm_wr_en_q   <= 1'b0;
      ifm_wr_addr_q <= '0;
      wr_data_q     <= '0;
    end else begin
      w_wr_en_q   <= '0;
      ifm_wr_en_q <= 1'b0;
      if (accept && !abort) begin
        wr_data_q <= in_data;
        if (load_w) begin
          w_wr_en_q   <= NUM_PE'(1) << cnt_q[SHIFT_W-1:0];
          w_wr_addr_q <= cnt_q >> SHIFT_W;
        end else begin
          ifm_wr_en_q   <= 1'b1;
          ifm_wr_addr_q <= cnt_q;
        end
      end
    end
  end

  assign w_wr_en     = w_wr_en_q;
  assign w_wr_addr   = w_wr_addr_q;
  assign ifm_wr_en   = ifm_wr_en_q;
  assign ifm_wr_addr = ifm_wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cal_start   = (state_q == COMPUTE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

  ofm_serializer u_ofm_serializer (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (abort),
    .capture_en_i (state_q == COMPUTE),
    .ovf_clr_i    (ovf_clr),
    .vec_i        (ofm_vec),
    .vec_valid_i  (ofm_vec_valid),
    .ofm_data_o   (ofm_data),
    .ofm_lane_o   (ofm_lane),
    .ofm_valid_o  (ofm_valid),
    .ofm_ready_i  (ofm_ready),
    .full_next_o  (buf_full_d),
    .overflow_o   (overflow)
  );

endmodule

// File: tb/tb_mbconv_layer_sequencer.sv
// tb/tb_mbconv_layer_sequencer.sv - bench with a transaction-level reference model of the layer sequencer
module tb_mbconv_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, run, abort, in_valid, done_compute, ofm_vec_valid, ofm_ready;
  logic [31:0]  w_words, ifm_words, in_data;
  logic [127:0] ofm_vec;
  logic         in_ready, ifm_wr_en, cal_start, ofm_valid, busy, done, overflow;
  logic [15:0]  w_wr_en;
  logic [31:0]  w_wr_addr, ifm_wr_addr, wr_data;
  logic [7:0]   ofm_data;
  logic [3:0]   ofm_lane;

  mbconv_layer_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .abort(abort),
    .w_words(w_words), .ifm_words(ifm_words), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .ifm_wr_en(ifm_wr_en),
    .ifm_wr_addr(ifm_wr_addr), .wr_data(wr_data), .cal_start(cal_start),
    .done_compute(done_compute), .ofm_vec(ofm_vec), .ofm_vec_valid(ofm_vec_valid),
    .ofm_data(ofm_data), .ofm_lane(ofm_lane), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: phase 0 idle, 1 weights, 2 ifm, 3 compute, 4 drain, 5 done.
  int          m_phase = 0;
  logic [31:0] m_acc = 0, m_wtot = 0, m_itot = 0;
  logic [7:0]  m_buf[16];
  bit          m_full = 0, m_ovf = 0;
  int          m_next = 0;
  bit          pw_v = 0, pw_w = 0;
  int          pw_lane = 0;
  logic [31:0] pw_addr = 0, pw_data = 0;
  bit          acc;
  logic [15:0] e_wen;

  int          n_wwr = 0, n_iwr = 0, hs15_cyc = 0, done_cyc = 0;
  logic [31:0] last_waddr = 0, last_iaddr = 0, first_iaddr = 0;
  bit          first_i_seen = 0;
  logic [7:0]  beats[$];
  int          beat_lanes[$];
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    e_wen = (pw_v && pw_w) ? (16'd1 << pw_lane) : 16'd0;
    chk("busy", busy, m_phase != 0);
    chk("in_ready", in_ready, m_phase == 1 || m_phase == 2);
    chk("cal_start", cal_start, m_phase == 3);
    chk("done", done, m_phase == 5);
    chk("overflow", overflow, m_ovf);
    chk("ofm_valid", ofm_valid, m_full);
    chk("w_wr_en", w_wr_en, e_wen);
    chk("ifm_wr_en", ifm_wr_en, pw_v && !pw_w);
    if (pw_v) chk("wr_data", wr_data, pw_data);
    if (pw_v && pw_w) chk("w_wr_addr", w_wr_addr, pw_addr);
    if (pw_v && !pw_w) chk("ifm_wr_addr", ifm_wr_addr, pw_addr);
    if (m_full) begin
      chk("ofm_data", ofm_data, m_buf[m_next]);
      chk("ofm_lane", ofm_lane, m_next);
    end

    if (w_wr_en != 0) begin n_wwr++; last_waddr = w_wr_addr; end
    if (ifm_wr_en) begin
      n_iwr++;
      last_iaddr = ifm_wr_addr;
      if (!first_i_seen) begin first_iaddr = ifm_wr_addr; first_i_seen = 1; end
    end
    if (ofm_valid && ofm_ready) begin
      beats.push_back(ofm_data);
      beat_lanes.push_back(int'(ofm_lane));
      if (ofm_lane == 4'd15) hs15_cyc = cyc;
    end
    if (done) done_cyc = cyc;

    if (reset) begin
      m_phase = 0; m_acc = 0; m_full = 0; m_next = 0; m_ovf = 0; pw_v = 0;
      for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
    end else begin
      acc     = in_valid && (m_phase == 1 || m_phase == 2);
      pw_v    = acc && !abort;
      pw_w    = (m_phase == 1);
      pw_lane = int'(m_acc % 16);
      pw_addr = (m_phase == 1) ? m_acc / 16 : m_acc;
      pw_data = in_data;
      if (m_full && ofm_ready) begin
        m_next++;
        if (m_next == 16) begin m_full = 0; m_next = 0; end
      end
      if (m_phase == 3 && ofm_vec_valid) begin
        if (!m_full) begin
          for (int i = 0; i < 16; i++) m_buf[i] = ofm_vec[8*i +: 8];
          m_full = 1;
          m_next = 0;
        end else begin
          m_ovf = 1;
        end
      end
      if (abort) begin
        m_phase = 0; m_acc = 0; m_full = 0; m_next = 0;
      end else begin
        case (m_phase)
          0: if (run) begin
            m_wtot = w_words * 16;
            m_itot = ifm_words;
            m_ovf  = 0;
            m_acc  = 0;
            m_phase = (m_wtot != 0) ? 1 : (m_itot != 0) ? 2 : 3;
          end
          1: if (acc) begin
            m_acc++;
            if (m_acc == m_wtot) begin m_acc = 0; m_phase = (m_itot != 0) ? 2 : 3; end
          end
          2: if (acc) begin
            m_acc++;
            if (m_acc == m_itot) begin m_acc = 0; m_phase = 3; end
          end
          3: if (done_compute) m_phase = m_full ? 4 : 5;
          4: if (!m_full) m_phase = 5;
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    in_data = $urandom();
    case (rdy_mode)
      0: ofm_ready = 1'b1;
      1: ofm_ready = ~ofm_ready;
      2: ofm_ready = 1'b0;
      default: ofm_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic finish_layer();
    done_compute = 1'b1;
    nxt();
    done_compute = 1'b0;
    for (int k = 0; k < 60 && busy; k++) nxt();
    chk("layer_back_to_idle", busy, 1'b0);
  endtask

  initial begin
    reset = 1; run = 0; abort = 0; in_valid = 0; done_compute = 0;
    ofm_vec_valid = 0; ofm_ready = 1; w_words = 0; ifm_words = 0; in_data = 0; ofm_vec = '0;
    nxt(); nxt();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_w_wr_en", w_wr_en, 0);
    chk("rst_w_wr_addr", w_wr_addr, 0);
    chk("rst_ifm_wr_en", ifm_wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cal_start", cal_start, 0);
    chk("rst_ofm_valid", ofm_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    reset = 0;
    nxt();

    // 1: 2 weight words per lane, 3 IFM words, continuous valid
    n_wwr = 0; n_iwr = 0;
    w_words = 2; ifm_words = 3; in_valid = 1; run = 1;
    nxt();
    run = 0;
    for (int k = 0; k < 100 && !cal_start; k++) nxt();
    chk("t1_reach_compute", cal_start, 1);
    nxt();
    in_valid = 0;
    finish_layer();
    chk("t1_w_writes", n_wwr, 32);
    chk("t1_last_w_addr", last_waddr, 1);
    chk("t1_ifm_writes", n_iwr, 3);
    chk("t1_last_ifm_addr", last_iaddr, 2);

    // 2: both loads skipped
    n_wwr = 0; n_iwr = 0;
    w_words = 0; ifm_words = 0; in_valid = 1; run = 1;
    nxt();
    run = 0;
    chk("t2_cal_start_next", cal_start, 1);
    chk("t2_in_ready", in_ready, 0);
    repeat (3) nxt();
    chk("t2_cal_start_held", cal_start, 1);
    done_compute = 1;
    nxt();
    done_compute = 0;
    chk("t2_cal_start_off", cal_start, 0);
    chk("t2_done", done, 1);
    nxt();
    chk("t2_done_one_cycle", done, 0);
    chk("t2_no_writes", n_wwr + n_iwr, 0);
    in_valid = 0;

    // 3: bytes 0..15 with toggling ready
    run = 1;
    nxt();
    run = 0;
    for (int i = 0; i < 16; i++) ofm_vec[8*i +: 8] = 8'(i);
    ofm_vec_valid = 1;
    rdy_mode = 1;
    beats.delete(); beat_lanes.delete();
    nxt();
    ofm_vec_valid = 0;
    for (int k = 0; k < 100 && beats.size() < 16; k++) nxt();
    chk("t3_beats", beats.size(), 16);
    for (int i = 0; i < 16 && i < beats.size(); i++) begin
      chk("t3_data", beats[i], i);
      chk("t3_lane", beat_lanes[i], i);
    end

    // 4: overflow with 5 lanes still pending
    for (int i = 0; i < 16; i++) ofm_vec[8*i +: 8] = 8'(8'hA0 + i);
    ofm_vec_valid = 1;
    rdy_mode = 0;
    nxt();
    ofm_vec_valid = 0;
    beats.delete(); beat_lanes.delete();
    for (int k = 0; k < 60 && beats.size() < 11; k++) nxt();
    rdy_mode = 2;
    ofm_ready = 0;
    for (int i = 0; i < 16; i++) ofm_vec[8*i +: 8] = 8'(8'hB0 + i);
    ofm_vec_valid = 1;
    nxt();
    ofm_vec_valid = 0;
    chk("t4_overflow", overflow, 1);
    rdy_mode = 0;
    for (int k = 0; k < 60 && beats.size() < 16; k++) nxt();
    chk("t4_beats", beats.size(), 16);
    for (int i = 11; i < 16 && i < beats.size(); i++) chk("t4_orig_data", beats[i], 8'hA0 + i);
    finish_layer();

    // 5: done_compute with a full buffer goes through DRAIN
    run = 1;
    nxt();
    run = 0;
    chk("t5_overflow_cleared", overflow, 0);
    for (int i = 0; i < 16; i++) ofm_vec[8*i +: 8] = 8'($urandom());
    ofm_vec_valid = 1;
    rdy_mode = 2;
    nxt();
    ofm_vec_valid = 0;
    done_compute = 1;
    nxt();
    done_compute = 0;
    chk("t5_drain_cal_start", cal_start, 0);
    chk("t5_drain_busy", busy, 1);
    chk("t5_drain_no_done", done, 0);
    rdy_mode = 0;
    for (int k = 0; k < 60 && !done; k++) nxt();
    chk("t5_done_seen", done, 1);
    nxt();
    chk("t5_done_latency", done_cyc - hs15_cyc, 1);

    // 6: abort mid-IFM, then restart
    w_words = 0; ifm_words = 4; run = 1;
    nxt();
    run = 0;
    in_valid = 1;
    nxt(); nxt();
    in_valid = 0; abort = 1;
    nxt();
    abort = 0;
    chk("t6_idle_busy", busy, 0);
    chk("t6_no_done", done, 0);
    chk("t6_in_ready", in_ready, 0);
    nxt();
    first_i_seen = 0; n_iwr = 0;
    run = 1; in_valid = 1;
    nxt();
    run = 0;
    for (int k = 0; k < 60 && !cal_start; k++) nxt();
    nxt();
    in_valid = 0;
    chk("t6_restart_addr0", first_iaddr, 0);
    chk("t6_restart_writes", n_iwr, 4);
    finish_layer();

    // Randomized traffic
    rdy_mode = 3;
    for (int n = 0; n < 5000; n++) begin
      reset         = ($urandom_range(0, 999) == 0);
      run           = ($urandom_range(0, 7) == 0);
      abort         = ($urandom_range(0, 299) == 0);
      in_valid      = ($urandom_range(0, 1) == 0);
      done_compute  = ($urandom_range(0, 24) == 0);
      ofm_vec_valid = ($urandom_range(0, 7) == 0);
      ofm_vec       = {$urandom(), $urandom(), $urandom(), $urandom()};
      w_words       = $urandom_range(0, 3);
      ifm_words     = $urandom_range(0, 5);
      nxt();
    end
    reset = 0; run = 0; abort = 0; in_valid = 0; done_compute = 0; ofm_vec_valid = 0;
    repeat (4) nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
